keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scanning controller for the 4x4 matrix keypad on the CPU's keypad I/O port. It drives the keypad rows and samples the columns, and debounces presses and releases. Each accepted key is encoded and pushed into a 4-entry FIFO. The FIFO is exposed to the I/O multiplexer as a status bit (`ready`) plus a head-of-queue data nibble (`keyout`) with an `ack` pop handshake, so the CPU can poll the keypad status address and read/acknowledge the keypad data address.

## Interface
- `SCAN_DIV`, 50000: clock cycles per scan tick (row dwell / sample period); minimum 2.
- `DEBOUNCE_SCANS`, 4: consecutive stable ticks required to accept a press or a release; minimum 1.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `colread`  in  4  keypad columns, active-low, asynchronous to `clk`.
- `rowwrite`  out  4  row drive, active-low one-hot.
- `ack`  in  1  pop request from the I/O multiplexer (level; may stay high for several cycles).
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `keyout`  out  4  key code at the FIFO head; 4'h0 when the FIFO is empty.
- `ready`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky flag: a key was dropped because the FIFO was full.

## Operation
- `colread` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- A divider counts 0..SCAN_DIV-1. `tick` is asserted when the count equals SCAN_DIV-1, and the divider then wraps to 0.
- Row index `idx` is 0..3. `rowwrite` = ~(4'b0001 << idx).
- Key code = 4*row + col. Column c corresponds to `colread[c]` being low.
- FSM states:
  - SCAN, on tick:
    - If the sample is 4'b1111, `idx` advances by 1 (wrapping 3->0).
    - Otherwise the controller latches the pattern, clears the debounce counter, and goes to DEBOUNCE. `idx` stays held.
  - DEBOUNCE, on tick:
    - If the sample is not equal to the latched pattern, `idx` advances by 1 and the FSM returns to SCAN.
    - If it is equal, the counter increments. When the counter reaches DEBOUNCE_SCANS, the FSM goes to HELD.
    - On that HELD transition, a push occurs only if exactly one column is low. A multi-column pattern is discarded with no push.
  - HELD, on tick:
    - A sample of 4'b1111 increments the release counter. Any other sample clears it.
    - When the release counter reaches DEBOUNCE_SCANS, `idx` advances by 1 and the FSM returns to SCAN.
    - While in HELD, `rowwrite` stays on the held row.
- FIFO: 4 entries with 2-bit read/write pointers that wrap, plus a 3-bit count from 0 to 4.
  - `pop` = `ack` & ~`ack_q`, i.e. the rising edge of `ack`. A multi-cycle `ack` therefore pops exactly once.
  - A pop while empty is ignored.
  - A push while not full stores the entry.
  - A push while full with no pop drops the new key and sets `overflow`.
  - A push and a pop in the same cycle both take effect and the count is unchanged. This holds when full too, and `overflow` is not set in that case.
  - A push and a pop in the same cycle while empty: the pop is ignored and the push is stored.
  - `clr_ovf` clears `overflow`. If `clr_ovf` and an overflow event occur in the same cycle, the set wins.

## Timing
- Reset values, applied immediately on `rst_n` low and independent of `clk`:
  - `rowwrite`=4'b1110, `ready`=0, `keyout`=4'h0, `overflow`=0.
  - FSM=SCAN, `idx`=0, divider=0, FIFO empty, synchronizer=4'b1111, `ack_q`=0.
- Reset asserted mid-operation discards any in-progress debounce and all FIFO contents.
- All outputs are registered or decoded from registers; there is no combinational path from `colread` or `ack` to any output.
- Row dwell is SCAN_DIV cycles, so one full idle scan takes 4*SCAN_DIV cycles.
- Push latency: the push occurs on the DEBOUNCE_SCANS-th tick after the detecting tick. Total latency from a stable press to the push is (DEBOUNCE_SCANS+1)*SCAN_DIV cycles plus up to 4*SCAN_DIV of scan phase plus 2 synchronizer cycles.
- `ready` and `keyout` update in the cycle after the push edge.
- After a pop, `keyout` shows the next entry and `ready` reflects the new count from the cycle after the `ack` rising edge.
- `ack` low-to-high again is required for the next pop.

## Test plan
Benches run with SCAN_DIV=4 and DEBOUNCE_SCANS=2.
- Reset, no keys -> `rowwrite` sequence 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; `ready`=0; `keyout`=0; `overflow`=0.
- `colread`=4'b1101 whenever `rowwrite`=4'b1011 (row2 col1), held 200 cycles -> exactly one push, `keyout`=4'h9, `ready`=1. Then `ack` high for 3 cycles -> exactly one pop; `ready`=0 and `keyout`=0 on the next cycle.
- Press visible for only 1 tick and then released (bounce) -> FSM returns to SCAN and no push occurs. A held release shorter than 2 ticks followed by a re-press -> still one key total.
- Keys 0x1, 0x6, 0xB, 0xC, 0x3 pressed and released in sequence with no `ack` -> after the 5th key, `overflow`=1 and count=4. Four `ack` pulses return 1, 6, B, C, then `ready`=0. `clr_ovf` -> `overflow`=0.
- Row0 `colread`=4'b1100 (two columns) -> no push. The scan stays frozen on row0 (`rowwrite`=1110) until released for 2 ticks.
- FIFO full with a push coinciding with an `ack` rising edge -> count stays 4, the oldest entry is removed, the new entry is stored, `overflow` stays 0. Separately, `rst_n` pulsed low during DEBOUNCE -> reset values apply immediately, with no `clk` edge required.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: drives rows, debounces press and release, and queues single-key codes in a 4-entry FIFO.
// A push lands DEBOUNCE_SCANS ticks after detection; a push into a full FIFO with no pop is dropped and flags overflow.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] colread,
    output logic [3:0] rowwrite,
    input  logic       ack,
    input  logic       clr_ovf,
    output logic [3:0] keyout,
    output logic       ready,
    output logic       overflow
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

    logic [3:0]       col_s1_q, col_s2_q;
    logic [DIV_W-1:0] div_q;
    state_t           state_q;
    logic [1:0]       idx_q;
    logic [3:0]       pat_q;
    logic [DEB_W-1:0] deb_cnt_q, rel_cnt_q;
    logic [DEB_W-1:0] deb_inc, rel_inc;
    logic             ack_q;
    logic [3:0]       mem_q [4];
    logic [1:0]       wr_ptr_q, rd_ptr_q;
    logic [2:0]       cnt_q, cnt_d;
    logic             ovf_q;

    logic       tick, stable, deb_done, single_col, push, pop, full, wr_en;
    logic [1:0] col_idx;

    assign tick       = (div_q == DIV_LAST);
    assign stable     = (col_s2_q == pat_q);
    assign deb_inc    = deb_cnt_q + DEB_W'(1);
    assign rel_inc    = rel_cnt_q + DEB_W'(1);
    assign deb_done   = (deb_inc == DEB_DONE);
    assign single_col = $onehot(~pat_q);

    always_comb begin
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!pat_q[c]) col_idx = 2'(c);
        end
    end

    // Push is qualified on the same tick edge that moves DEBOUNCE to HELD.
    assign push = tick && (state_q == ST_DEBOUNCE) && stable && deb_done && single_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
            div_q    <= '0;
        end else begin
            col_s1_q <= colread;
            col_s2_q <= col_s1_q;
            div_q    <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SCAN;
            idx_q     <= 2'd0;
            pat_q     <= 4'hF;
            deb_cnt_q <= '0;
            rel_cnt_q <= '0;
        end else if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (col_s2_q == 4'hF) begin
                        idx_q <= idx_q + 2'd1;
                    end else begin
                        pat_q     <= col_s2_q;
                        deb_cnt_q <= '0;
                        state_q   <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!stable) begin
                        idx_q   <= idx_q + 2'd1;
                        state_q <= ST_SCAN;
                    end else if (deb_done) begin
                        rel_cnt_q <= '0;
                        state_q   <= ST_HELD;
                    end else begin
                        deb_cnt_q <= deb_inc;
                    end
                end
                ST_HELD: begin
                    if (col_s2_q != 4'hF) begin
                        rel_cnt_q <= '0;
                    end else if (rel_inc == DEB_DONE) begin
                        idx_q   <= idx_q + 2'd1;
                        state_q <= ST_SCAN;
                    end else begin
                        rel_cnt_q <= rel_inc;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    // A pop into an empty FIFO is ignored; a pop frees a slot for a same-cycle push when full.
    assign pop   = ack && !ack_q && (cnt_q != 3'd0);
    assign full  = (cnt_q == 3'd4);
    assign wr_en = push && (!full || pop);

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !pop)      cnt_d = cnt_q + 3'd1;
        else if (!wr_en && pop) cnt_d = cnt_q - 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < 4; i++) mem_q[i] <= 4'h0;
        end else begin
            ack_q <= ack;
            cnt_q <= cnt_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {idx_q, col_idx};
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            if (push && full && !pop) ovf_q <= 1'b1;
            else if (clr_ovf)         ovf_q <= 1'b0;
        end
    end

    assign rowwrite = ~(4'b0001 << idx_q);
    assign ready    = (cnt_q != 3'd0);
    assign keyout   = ready ? mem_q[rd_ptr_q] : 4'h0;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model drives colread from rowwrite; expected keys go through a scoreboard queue.
module tb_keypad_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, ack, clr_ovf;
    logic [3:0]  colread, rowwrite, keyout;
    logic        ready, overflow;
    logic [15:0] keys_down;
    logic [3:0]  exp_q [$];
    bit          exp_ovf;
    int          n_pass = 0;
    int          n_total = 0;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .rst_n(rst_n), .colread(colread), .rowwrite(rowwrite),
        .ack(ack), .clr_ovf(clr_ovf), .keyout(keyout), .ready(ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Pressed switches connect a driven (low) row to their column.
    always_comb begin
        colread = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!rowwrite[r])
                for (int c = 0; c < 4; c++)
                    if (keys_down[4*r+c]) colread[c] = 1'b0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_push(input logic [3:0] code);
        if (exp_q.size() < 4) exp_q.push_back(code);
        else exp_ovf = 1'b1;
    endtask

    task automatic press_release(input logic [15:0] mask, input int hold, input int rel);
        keys_down = mask;
        cyc(hold);
        keys_down = 16'h0;
        cyc(rel);
    endtask

    task automatic ack_pulse(input int len);
        ack = 1'b1;
        cyc(len);
        ack = 1'b0;
        cyc(1);
    endtask

    task automatic drain_directed(input string tag);
        logic [3:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " ready"}, ready, 1);
            check({tag, " keyout"}, keyout, e);
            ack_pulse(int'($urandom_range(1, 4)));
        end
        check({tag, " empty ready"}, ready, 0);
        check({tag, " empty keyout"}, keyout, 0);
    endtask

    // Press a key right after the scan lands on its row, so the push edge is 12 cycles later.
    task automatic press_aligned(input logic [3:0] code);
        logic [3:0] target, prev;
        bit         ok;
        target = ~(4'b0001 << code[3:2]);
        prev   = rowwrite;
        ok     = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (rowwrite == target && prev != target) ok = 1'b1;
            prev = rowwrite;
        end
        check("row align", ok, 1);
        keys_down = 16'h0001 << code;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (ready) begin
                check("sb has entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb keyout", keyout, exp_q.pop_front());
                cyc(int'($urandom_range(0, 3)));
                ack = 1'b1;
                cyc(int'($urandom_range(1, 3)));
                ack = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0] r1, exp_row;
        logic [3:0] seq [5];
        int         kind, hold, rel;
        logic [1:0] row, c1, c2;

        rst_n = 1'b0; ack = 1'b0; clr_ovf = 1'b0; keys_down = 16'h0; exp_ovf = 1'b0;
        #1;
        check("reset rowwrite", rowwrite, 4'b1110);
        check("reset ready", ready, 0);
        check("reset keyout", keyout, 0);
        check("reset overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            check("idle rowwrite", rowwrite, exp_row);
        end
        check("idle ready", ready, 0);

        // Row 2, column 1: single held key, then a 3-cycle ack pops once.
        keys_down = 16'h0001 << 9;
        cyc(200);
        keys_down = 16'h0;
        cyc(30);
        check("key9 ready", ready, 1);
        check("key9 keyout", keyout, 4'h9);
        ack = 1'b1;
        cyc(1);
        check("key9 pop ready", ready, 0);
        check("key9 pop keyout", keyout, 0);
        cyc(2);
        ack = 1'b0;
        cyc(1);
        check("key9 after ack ready", ready, 0);

        // Short bounces never reach three matching ticks.
        for (int i = 0; i < 4; i++)
            press_release(16'h0001 << $urandom_range(0, 15), int'($urandom_range(1, 6)), 30);
        drain_directed("bounce");
        // A brief release gap inside a hold is not a release.
        keys_down = 16'h0001 << 14;
        cyc(60);
        keys_down = 16'h0;
        cyc(3);
        press_release(16'h0001 << 14, 60, 40);
        model_push(4'hE);
        drain_directed("short release");

        // Two columns on row 0: no push and the scan stays frozen.
        keys_down = 16'h0003;
        cyc(40);
        check("multi frozen a", rowwrite, 4'b1110);
        cyc(13);
        check("multi frozen b", rowwrite, 4'b1110);
        keys_down = 16'h0;
        cyc(30);
        r1 = rowwrite;
        cyc(4);
        check("multi scan resumes", rowwrite, {r1[2:0], r1[3]});
        drain_directed("multi");

        // Five keys with no ack: the fifth is dropped.
        seq = '{4'h1, 4'h6, 4'hB, 4'hC, 4'h3};
        for (int i = 0; i < 5; i++) begin
            press_release(16'h0001 << seq[i], 60, 30);
            model_push(seq[i]);
            check("ovf fill overflow", overflow, exp_ovf);
        end
        drain_directed("ovf drain");
        check("ovf sticky", overflow, 1);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        check("ovf cleared", overflow, exp_ovf);

        // Full FIFO: push and ack rising edge land on the same clock edge.
        seq[0] = 4'h2; seq[1] = 4'h4; seq[2] = 4'h8; seq[3] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            press_release(16'h0001 << seq[i], 60, 30);
            model_push(seq[i]);
        end
        press_aligned(4'hD);
        cyc(11);
        check("coinc head", keyout, exp_q[0]);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(4'hD);
        check("coinc overflow", overflow, exp_ovf);
        check("coinc ready", ready, 1);
        cyc(48);
        keys_down = 16'h0;
        cyc(30);
        check("coinc overflow late", overflow, exp_ovf);
        drain_directed("coinc drain");

        // Asynchronous reset in the middle of a debounce with a queued key.
        press_release(16'h0001 << 5, 60, 30);
        model_push(4'h5);
        check("pre reset ready", ready, 1);
        press_aligned(4'hA);
        cyc(6);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset rowwrite", rowwrite, 4'b1110);
        check("async reset ready", ready, 0);
        check("async reset keyout", keyout, 0);
        check("async reset overflow", overflow, 0);
        exp_q.delete();
        keys_down = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(40);
        drain_directed("post reset");

        // Randomized traffic with a free-running consumer.
        fork
            monitor();
        join_none
        for (int it = 0; it < 14; it++) begin
            kind = int'($urandom_range(0, 3));
            row  = 2'($urandom_range(0, 3));
            c1   = 2'($urandom_range(0, 3));
            hold = int'($urandom_range(60, 120));
            rel  = int'($urandom_range(30, 60));
            case (kind)
                0, 1: begin
                    exp_q.push_back({row, c1});
                    press_release(16'h0001 << {row, c1}, hold, rel);
                end
                2: begin
                    c2 = c1 + 2'($urandom_range(1, 3));
                    press_release((16'h0001 << {row, c1}) | (16'h0001 << {row, c2}), hold, rel);
                end
                default: press_release(16'h0001 << {row, c1}, int'($urandom_range(1, 6)), rel);
            endcase
        end
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("random drained", exp_q.size(), 0);
        cyc(10);
        check("random final ready", ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
